spi8_mem_ctrl: RTL and testbench

//   Sequencer for the octal-SPI DDR memory interface on the 192 MHz clk4 domain (spi8ddr pad

---
 rtl/spi8_mem_ctrl_if.sv | 32 +++
 rtl/spi8_mem_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_spi8_mem_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi8_mem_ctrl_if.sv
// Request, write/read data and pad-side signals of the octal-SPI DDR sequencer.
// The master modport is the requester/pad side; the slave modport is the sequencer.
interface spi8_mem_ctrl_if;
   logic        req;
   logic        req_wr;
   logic [31:0] req_addr;
   logic [7:0]  req_len;
   logic        req_ack;
   logic        busy;
   logic        done;
   logic [15:0] wdata;
   logic        wdata_rd;
   logic [15:0] rdata;
   logic        rdata_valid;
   logic        spi_ncs;
   logic        spi_oe;
   logic [15:0] spi_dout;
   logic [15:0] spi_din;
   logic        spi_nrst;

   modport master (
      output req, req_wr, req_addr, req_len, wdata, spi_din,
      input  req_ack, busy, done, wdata_rd, rdata, rdata_valid,
      input  spi_ncs, spi_oe, spi_dout, spi_nrst
   );

   modport slave (
      input  req, req_wr, req_addr, req_len, wdata, spi_din,
      output req_ack, busy, done, wdata_rd, rdata, rdata_valid,
      output spi_ncs, spi_oe, spi_dout, spi_nrst
   );
endinterface

// File: rtl/spi8_mem_ctrl.sv
// Octal-SPI DDR memory sequencer: device power-up sequence, then one
// command/address/latency/data burst per request with a fixed-latency read return.
module spi8_mem_ctrl #(
   parameter logic [7:0]  CMD_RD   = 8'hEE,
   parameter logic [7:0]  CMD_WR   = 8'h12,
   parameter int unsigned LAT      = 6,
   parameter int unsigned RD_DLY   = 3,
   parameter int unsigned CS_HIGH  = 4,
   parameter int unsigned RST_LO   = 16,
   parameter int unsigned RST_WAIT = 32
) (
   input logic            i_clk,
   input logic            i_reset,
   spi8_mem_ctrl_if.slave io_bus
);

   // The IDLE cycle that follows CS_GAP also has ncs high, so the gap state itself
   // is one shorter to give exactly CS_HIGH high cycles between back-to-back bursts.
   localparam int unsigned GAP_CYCLES = (CS_HIGH > 1) ? CS_HIGH - 1 : 1;

   localparam logic [15:0] LIM_RST_LO   = 16'(RST_LO - 1);
   localparam logic [15:0] LIM_RST_WAIT = 16'(RST_WAIT - 1);
   localparam logic [15:0] LIM_LAT      = 16'(LAT - 1);
   localparam logic [15:0] LIM_GAP      = 16'(GAP_CYCLES - 1);

   typedef enum logic [3:0] {
      StRstLo,
      StRstWait,
      StIdle,
      StCmd,
      StAddrHi,
      StAddrLo,
      StLatency,
      StData,
      StCsGap
   } state_t;

   state_t      r_state;
   state_t      w_state_d;
   logic [15:0] r_cnt;
   logic [15:0] w_cnt_d;
   logic        w_latch;

   logic        r_wr;
   logic [31:0] r_addr;
   logic [8:0]  r_len;

   logic        r_ncs,  w_ncs_d;
   logic        r_oe,   w_oe_d;
   logic [15:0] r_dout, w_dout_d;
   logic        r_nrst, w_nrst_d;
   logic        r_busy, w_busy_d;
   logic        r_ack;
   logic        r_done, w_done_d;
   logic        w_wdata_rd;
   logic        w_rd_beat;

   logic [RD_DLY-1:0] r_pv;
   logic [15:0]       r_pd [RD_DLY];

   always_comb begin
      w_state_d = r_state;
      w_cnt_d   = r_cnt + 16'd1;
      w_latch   = 1'b0;
      unique case (r_state)
         StRstLo: begin
            if (r_cnt == LIM_RST_LO) begin
               w_state_d = StRstWait;
               w_cnt_d   = '0;
            end
         end
         StRstWait: begin
            if (r_cnt == LIM_RST_WAIT) begin
               w_state_d = StIdle;
               w_cnt_d   = '0;
            end
         end
         StIdle: begin
            w_cnt_d = '0;
            if (io_bus.req) begin
               w_state_d = StCmd;
               w_latch   = 1'b1;
            end
         end
         StCmd: begin
            w_state_d = StAddrHi;
            w_cnt_d   = '0;
         end
         StAddrHi: begin
            w_state_d = StAddrLo;
            w_cnt_d   = '0;
         end
         StAddrLo: begin
            w_state_d = StLatency;
            w_cnt_d   = '0;
         end
         StLatency: begin
            if (r_cnt == LIM_LAT) begin
               w_state_d = StData;
               w_cnt_d   = '0;
            end
         end
         StData: begin
            if (r_cnt == {7'd0, r_len - 9'd1}) begin
               w_state_d = StCsGap;
               w_cnt_d   = '0;
            end
         end
         StCsGap: begin
            if (r_cnt == LIM_GAP) begin
               w_state_d = StIdle;
               w_cnt_d   = '0;
            end
         end
         default: begin
            w_state_d = StRstLo;
            w_cnt_d   = '0;
         end
      endcase
   end

   // Outputs are registered images of the next state, so they line up with r_state.
   always_comb begin
      w_ncs_d  = 1'b1;
      w_oe_d   = 1'b0;
      w_dout_d = '0;
      w_nrst_d = (w_state_d != StRstLo);
      w_busy_d = (w_state_d != StIdle);
      w_done_d = (w_state_d == StCsGap) && (r_state != StCsGap);
      case (w_state_d)
         StCmd: begin
            w_ncs_d  = 1'b0;
            w_oe_d   = 1'b1;
            w_dout_d = io_bus.req_wr ? {CMD_WR, ~CMD_WR} : {CMD_RD, ~CMD_RD};
         end
         StAddrHi: begin
            w_ncs_d  = 1'b0;
            w_oe_d   = 1'b1;
            w_dout_d = r_addr[31:16];
         end
         StAddrLo: begin
            w_ncs_d  = 1'b0;
            w_oe_d   = 1'b1;
            w_dout_d = r_addr[15:0];
         end
         StLatency: begin
            w_ncs_d = 1'b0;
            w_oe_d  = r_wr;
         end
         StData: begin
            w_ncs_d  = 1'b0;
            w_oe_d   = r_wr;
            w_dout_d = r_wr ? io_bus.wdata : 16'd0;
         end
         default: ;
      endcase
   end

   // A word is popped on the cycle before each write data cycle.
   assign w_wdata_rd = r_wr && (w_state_d == StData);
   assign w_rd_beat  = (r_state == StData) && !r_wr;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state <= StRstLo;
         r_cnt   <= '0;
         r_wr    <= 1'b0;
         r_addr  <= '0;
         r_len   <= '0;
         r_ncs   <= 1'b1;
         r_oe    <= 1'b0;
         r_dout  <= '0;
         r_nrst  <= 1'b0;
         r_busy  <= 1'b1;
         r_ack   <= 1'b0;
         r_done  <= 1'b0;
         r_pv    <= '0;
         for (int i = 0; i < int'(RD_DLY); i++) begin
            r_pd[i] <= '0;
         end
      end else begin
         r_state <= w_state_d;
         r_cnt   <= w_cnt_d;
         if (w_latch) begin
            r_wr   <= io_bus.req_wr;
            r_addr <= io_bus.req_addr;
            r_len  <= {io_bus.req_len == 8'd0, io_bus.req_len};
         end
         r_ncs  <= w_ncs_d;
         r_oe   <= w_oe_d;
         r_dout <= w_dout_d;
         r_nrst <= w_nrst_d;
         r_busy <= w_busy_d;
         r_ack  <= w_latch;
         r_done <= w_done_d;
         for (int i = int'(RD_DLY) - 1; i > 0; i--) begin
            r_pv[i] <= r_pv[i-1];
            r_pd[i] <= r_pd[i-1];
         end
         r_pv[0] <= w_rd_beat;
         r_pd[0] <= io_bus.spi_din;
      end
   end

   assign io_bus.req_ack     = r_ack;
   assign io_bus.busy        = r_busy;
   assign io_bus.done        = r_done;
   assign io_bus.wdata_rd    = w_wdata_rd;
   assign io_bus.rdata       = r_pd[RD_DLY-1];
   assign io_bus.rdata_valid = r_pv[RD_DLY-1];
   assign io_bus.spi_ncs     = r_ncs;
   assign io_bus.spi_oe      = r_oe;
   assign io_bus.spi_dout    = r_dout;
   assign io_bus.spi_nrst    = r_nrst;

endmodule

// File: tb/tb_spi8_mem_ctrl.sv
// Bench for spi8_mem_ctrl: a burst-timeline model predicts every output per cycle,
// with directed bursts, randomized bursts and a mid-burst reset.
module tb_spi8_mem_ctrl;
   localparam logic [7:0] CMD_RD = 8'hEE;
   localparam logic [7:0] CMD_WR = 8'h12;
   localparam int LAT      = 6;
   localparam int RD_DLY   = 3;
   localparam int CS_HIGH  = 4;
   localparam int RST_LO   = 16;
   localparam int RST_WAIT = 32;
   localparam int MAXC     = 4096;

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [7:0]  len;
   } req_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   spi8_mem_ctrl_if bus ();

   spi8_mem_ctrl #(
      .CMD_RD  (CMD_RD),
      .CMD_WR  (CMD_WR),
      .LAT     (LAT),
      .RD_DLY  (RD_DLY),
      .CS_HIGH (CS_HIGH),
      .RST_LO  (RST_LO),
      .RST_WAIT(RST_WAIT)
   ) dut (
      .i_clk  (clk),
      .i_reset(rst),
      .io_bus (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   bit chk_en  = 1'b0;

   // Expected value of every output for each cycle since reset release.
   bit          e_ncs [MAXC];
   bit          e_oe  [MAXC];
   bit          e_nrst[MAXC];
   bit          e_busy[MAXC];
   bit          e_ack [MAXC];
   bit          e_done[MAXC];
   bit          e_wdrd[MAXC];
   bit          e_rv  [MAXC];
   bit          e_rbeat[MAXC];
   logic [15:0] e_dout[MAXC];
   logic [15:0] e_rd  [MAXC];
   int          next_idle;
   int          last_t;

   req_t        rq[$];
   logic [15:0] wq[$];

   int c_nrst_lo = 0, c_busy_hi = 0, c_ncs_lo = 0, c_oe_hi = 0;
   int c_wdrd = 0, c_rv = 0, c_done = 0;
   int hi_run = 0, last_gap = 0, ack_last = 0, ack_prev = 0;
   bit seen_low = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
      end
   endtask

   task automatic model_init();
      for (int c = 0; c < MAXC; c++) begin
         e_ncs[c]   = 1'b1;
         e_oe[c]    = 1'b0;
         e_nrst[c]  = (c >= RST_LO);
         e_busy[c]  = (c < RST_LO + RST_WAIT);
         e_ack[c]   = 1'b0;
         e_done[c]  = 1'b0;
         e_wdrd[c]  = 1'b0;
         e_rv[c]    = 1'b0;
         e_rbeat[c] = 1'b0;
         e_dout[c]  = '0;
         e_rd[c]    = '0;
      end
      next_idle = RST_LO + RST_WAIT;
   endtask

   // Lay out the whole burst accepted in idle cycle t.
   task automatic accept(input int t, input req_t r);
      int n;
      int d0;
      n  = (r.len == 8'd0) ? 256 : int'(r.len);
      d0 = t + 4 + LAT;
      if (d0 + n + CS_HIGH + RD_DLY + 2 >= MAXC) begin
         $display("FAIL model_range cyc=%0d got=%0d want=<%0d", t, d0 + n, MAXC);
         $fatal(1, "model range exceeded");
      end
      last_t = t;
      e_ack[t+1]  = 1'b1;
      e_dout[t+1] = r.wr ? {CMD_WR, ~CMD_WR} : {CMD_RD, ~CMD_RD};
      e_dout[t+2] = r.addr[31:16];
      e_dout[t+3] = r.addr[15:0];
      for (int k = t + 1; k <= t + 3; k++) e_oe[k] = 1'b1;
      for (int k = t + 4; k < d0; k++) e_oe[k] = r.wr;
      for (int k = t + 1; k < d0 + n; k++) e_ncs[k] = 1'b0;
      for (int j = 0; j < n; j++) begin
         e_oe[d0+j] = r.wr;
         if (r.wr) e_wdrd[d0+j-1] = 1'b1;
         else begin
            e_rbeat[d0+j]      = 1'b1;
            e_rv[d0+j+RD_DLY]  = 1'b1;
         end
      end
      e_done[d0+n] = 1'b1;
      next_idle = d0 + n + CS_HIGH - 1;
      for (int k = t + 1; k < next_idle; k++) e_busy[k] = 1'b1;
   endtask

   task automatic drive_step();
      if (rq.size() > 0) begin
         bus.req      = 1'b1;
         bus.req_wr   = rq[0].wr;
         bus.req_addr = rq[0].addr;
         bus.req_len  = rq[0].len;
      end else begin
         bus.req      = 1'b0;
         bus.req_wr   = 1'($urandom);
         bus.req_addr = $urandom;
         bus.req_len  = 8'($urandom);
      end
      if (e_wdrd[cyc] && wq.size() > 0) bus.wdata = wq.pop_front();
      else bus.wdata = 16'($urandom);
      bus.spi_din = 16'($urandom);
      if (bus.req && cyc >= next_idle) begin
         accept(cyc, rq[0]);
         void'(rq.pop_front());
      end
      if (e_wdrd[cyc]) e_dout[cyc+1] = bus.wdata;
      if (e_rbeat[cyc]) e_rd[cyc+RD_DLY] = bus.spi_din;
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
      cyc++;
      drive_step();
   endtask

   task automatic run_until_idle();
      int lim = 0;
      while ((rq.size() > 0 || cyc < next_idle) && lim < 2000) begin
         cycle();
         lim++;
      end
      if (lim >= 2000) chk("idle_timeout", 32'(lim), 32'(0));
      repeat (2) cycle();
   endtask

   task automatic push_req(input bit wr, input logic [31:0] addr, input logic [7:0] len);
      req_t r;
      r.wr   = wr;
      r.addr = addr;
      r.len  = len;
      rq.push_back(r);
   endtask

   task automatic release_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_init();
      cyc = 0;
      rq.delete();
      wq.delete();
      drive_step();
      chk_en = 1'b1;
   endtask

   task automatic check_init_seq(input string tag);
      int s_lo, s_busy, s_ncs, s_oe;
      s_lo = c_nrst_lo; s_busy = c_busy_hi; s_ncs = c_ncs_lo; s_oe = c_oe_hi;
      repeat (60) cycle();
      chk({tag, "_nrst_lo"}, 32'(c_nrst_lo - s_lo), 32'(16));
      chk({tag, "_busy_after_nrst"}, 32'(c_busy_hi - s_busy), 32'(32));
      chk({tag, "_ncs_lo"}, 32'(c_ncs_lo - s_ncs), 32'(0));
      chk({tag, "_oe_hi"}, 32'(c_oe_hi - s_oe), 32'(0));
   endtask

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (!chk_en) begin
         hi_run   = 0;
         seen_low = 1'b0;
      end else if (cyc < MAXC) begin
         chk("ncs", 32'(bus.spi_ncs), 32'(e_ncs[cyc]));
         chk("oe", 32'(bus.spi_oe), 32'(e_oe[cyc]));
         chk("dout", 32'(bus.spi_dout), 32'(e_dout[cyc]));
         chk("nrst", 32'(bus.spi_nrst), 32'(e_nrst[cyc]));
         chk("busy", 32'(bus.busy), 32'(e_busy[cyc]));
         chk("req_ack", 32'(bus.req_ack), 32'(e_ack[cyc]));
         chk("done", 32'(bus.done), 32'(e_done[cyc]));
         chk("wdata_rd", 32'(bus.wdata_rd), 32'(e_wdrd[cyc]));
         chk("rdata_valid", 32'(bus.rdata_valid), 32'(e_rv[cyc]));
         if (e_rv[cyc]) chk("rdata", 32'(bus.rdata), 32'(e_rd[cyc]));
         if (!bus.spi_nrst) c_nrst_lo++;
         if (bus.busy && bus.spi_nrst) c_busy_hi++;
         if (!bus.spi_ncs) c_ncs_lo++;
         if (bus.spi_oe) c_oe_hi++;
         if (bus.wdata_rd) c_wdrd++;
         if (bus.rdata_valid) c_rv++;
         if (bus.done) c_done++;
         if (bus.req_ack) begin
            ack_prev = ack_last;
            ack_last = cyc;
         end
         if (bus.spi_ncs) hi_run++;
         else begin
            if (seen_low && hi_run > 0) last_gap = hi_run;
            hi_run   = 0;
            seen_low = 1'b1;
         end
      end
   end

   initial begin
      int s_ncs, s_oe, s_rv, s_wd, s_done, lim;
      bus.req = 1'b0; bus.req_wr = 1'b0; bus.req_addr = '0; bus.req_len = '0;
      bus.wdata = '0; bus.spi_din = '0;
      model_init();

      // Reset values while reset is held.
      #22;
      chk("rst_ncs", 32'(bus.spi_ncs), 32'(1));
      chk("rst_oe", 32'(bus.spi_oe), 32'(0));
      chk("rst_dout", 32'(bus.spi_dout), 32'(0));
      chk("rst_nrst", 32'(bus.spi_nrst), 32'(0));
      chk("rst_busy", 32'(bus.busy), 32'(1));
      chk("rst_ack", 32'(bus.req_ack), 32'(0));
      chk("rst_done", 32'(bus.done), 32'(0));
      chk("rst_rv", 32'(bus.rdata_valid), 32'(0));
      chk("rst_rdata", 32'(bus.rdata), 32'(0));

      release_reset();
      check_init_seq("init");

      // Read len 4 at 0x0000_1234.
      s_ncs = c_ncs_lo; s_oe = c_oe_hi; s_rv = c_rv;
      push_req(1'b0, 32'h0000_1234, 8'd4);
      run_until_idle();
      chk("rd4_ncs_lo", 32'(c_ncs_lo - s_ncs), 32'(13));
      chk("rd4_oe_hi", 32'(c_oe_hi - s_oe), 32'(3));
      chk("rd4_rv", 32'(c_rv - s_rv), 32'(4));
      chk("pin_cmd_rd", 32'(e_dout[last_t+1]), 32'h0000_EE11);
      chk("pin_addr_hi", 32'(e_dout[last_t+2]), 32'h0000_0000);
      chk("pin_addr_lo", 32'(e_dout[last_t+3]), 32'h0000_1234);

      // Write len 2 with A5A5 then 5A5A.
      s_oe = c_oe_hi; s_wd = c_wdrd; s_done = c_done;
      wq.push_back(16'hA5A5);
      wq.push_back(16'h5A5A);
      push_req(1'b1, 32'hDEAD_BEEF, 8'd2);
      run_until_idle();
      chk("wr2_wdata_rd", 32'(c_wdrd - s_wd), 32'(2));
      chk("wr2_oe_hi", 32'(c_oe_hi - s_oe), 32'(11));
      chk("wr2_done", 32'(c_done - s_done), 32'(1));
      chk("pin_cmd_wr", 32'(e_dout[last_t+1]), 32'h0000_12ED);
      chk("pin_wd0", 32'(e_dout[last_t+4+LAT]), 32'h0000_A5A5);
      chk("pin_wd1", 32'(e_dout[last_t+5+LAT]), 32'h0000_5A5A);

      // Read len 0 means 256 words.
      s_ncs = c_ncs_lo; s_rv = c_rv;
      push_req(1'b0, $urandom, 8'd0);
      run_until_idle();
      chk("rd256_ncs_lo", 32'(c_ncs_lo - s_ncs), 32'(265));
      chk("rd256_rv", 32'(c_rv - s_rv), 32'(256));

      // req held high across two bursts.
      push_req(1'b0, $urandom, 8'd3);
      push_req(1'b1, $urandom, 8'd3);
      run_until_idle();
      chk("b2b_ncs_gap", 32'(last_gap), 32'(4));
      chk("b2b_ack_spacing", 32'(ack_last - ack_prev), 32'(16));

      // Randomized bursts, sometimes queued back to back.
      for (int i = 0; i < 30; i++) begin
         push_req(1'($urandom), $urandom, 8'($urandom_range(1, 24)));
         if ($urandom_range(0, 3) == 0) push_req(1'($urandom), $urandom, 8'($urandom_range(1, 8)));
         run_until_idle();
         repeat ($urandom_range(0, 3)) cycle();
      end

      // Reset in the middle of a read data phase.
      push_req(1'b0, $urandom, 8'd8);
      lim = 0;
      while (lim < 200) begin
         cycle();
         lim++;
         if (cyc >= 2 && e_rbeat[cyc] && e_rbeat[cyc-2]) break;
      end
      chk("mid_rd_reached", 32'(lim < 200), 32'(1));
      #2;
      rst    = 1'b1;
      chk_en = 1'b0;
      #1;
      chk("mid_rst_ncs", 32'(bus.spi_ncs), 32'(1));
      chk("mid_rst_oe", 32'(bus.spi_oe), 32'(0));
      chk("mid_rst_nrst", 32'(bus.spi_nrst), 32'(0));
      chk("mid_rst_busy", 32'(bus.busy), 32'(1));
      chk("mid_rst_rv", 32'(bus.rdata_valid), 32'(0));
      repeat (6) begin
         @(negedge clk);
         chk("hold_rst_rv", 32'(bus.rdata_valid), 32'(0));
         chk("hold_rst_ncs", 32'(bus.spi_ncs), 32'(1));
      end
      release_reset();
      s_rv = c_rv;
      check_init_seq("reinit");
      chk("reinit_no_rv", 32'(c_rv - s_rv), 32'(0));

      for (int i = 0; i < 6; i++) begin
         push_req(1'($urandom), $urandom, 8'($urandom_range(1, 12)));
         run_until_idle();
      end

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
